// File: rtl/proc_pkg.sv
// Shared execute-stage definitions: ALUOp classes, funct codes, ALU controls,
// multiplier FSM states and the combinational ALU helpers.
package proc_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ADD2  = 2'b11;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_MULT = 6'b011000;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_MUL,
      ALU_NONE
   } alu_ctl_e;

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_BUSY,
      MUL_DONE
   } mul_state_e;

   function automatic alu_ctl_e funct_dec(input logic [5:0] f);
      alu_ctl_e c;
      case (f)
         F_ADD:   c = ALU_ADD;
         F_SUB:   c = ALU_SUB;
         F_AND:   c = ALU_AND;
         F_OR:    c = ALU_OR;
         F_SLT:   c = ALU_SLT;
         F_MULT:  c = ALU_MUL;
         default: c = ALU_NONE;
      endcase
      return c;
   endfunction

   // mult is produced by the sequential unit; the ALU itself yields 0 for it
   function automatic logic [31:0] alu_calc(
      input alu_ctl_e    c,
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [31:0] r;
      case (c)
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative 32x32 shift-add multiplier: IDLE -> BUSY (32 steps) -> DONE.
// Instantiated by ex_stage only when EX_MUL_EN is defined.
module ex_mul_seq
   import proc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] product
);

   mul_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [63:0] prod_q, prod_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= MUL_IDLE;
         cnt_q    <= 5'd0;
         mcand_q  <= 64'd0;
         mplier_q <= 32'd0;
         prod_q   <= 64'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         MUL_IDLE: begin
            if (start) begin
               busy     = 1'b1;
               cnt_d    = 5'd0;
               mcand_d  = {32'd0, a};
               mplier_d = b;
               prod_d   = 64'd0;
               state_d  = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            busy     = 1'b1;
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : 64'd0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = MUL_DONE;
         end
         MUL_DONE: begin
            done    = 1'b1;
            state_d = MUL_IDLE;
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   assign product = prod_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolve and the EX/MEM register.
// Define EX_MUL_EN to add the stalling iterative multiplier (funct 011000).
module ex_stage
   import proc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ID_EX_ReadData1,
   input  logic [31:0] ID_EX_ReadData2,
   input  logic [31:0] ID_EX_SignExtImm,
   input  logic [4:0]  ID_EX_Rd,
   input  logic [4:0]  ID_EX_Rb,
   input  logic [7:0]  ID_EX_PC,
   input  logic        ID_EX_RegDst,
   input  logic        ID_EX_ALUSrc,
   input  logic        ID_EX_MemToReg,
   input  logic        ID_EX_RegWrite,
   input  logic        ID_EX_MemRead,
   input  logic        ID_EX_MemWrite,
   input  logic        ID_EX_Branch,
   input  logic [1:0]  ID_EX_ALUOp,
   output logic [31:0] EX_MEM_ALUResult,
   output logic [31:0] EX_MEM_WriteData,
   output logic [4:0]  EX_MEM_WriteReg,
   output logic        EX_MEM_MemToReg,
   output logic        EX_MEM_RegWrite,
   output logic        EX_MEM_MemRead,
   output logic        EX_MEM_MemWrite,
   output logic        BranchTaken,
   output logic [7:0]  BranchTarget,
   output logic        Stall
);

   alu_ctl_e    alu_ctl;
   logic [31:0] alu_b;
   logic [31:0] alu_res;
   logic [31:0] ex_res;
   logic        zero;
   logic [7:0]  tgt;

   logic [31:0] res_q, res_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  wreg_q, wreg_d;
   logic        m2r_q, m2r_d;
   logic        rw_q, rw_d;
   logic        mr_q, mr_d;
   logic        mw_q, mw_d;
   logic        bt_q, bt_d;
   logic [7:0]  btgt_q, btgt_d;

   assign alu_b = ID_EX_ALUSrc ? ID_EX_SignExtImm : ID_EX_ReadData2;

   always_comb begin
      alu_ctl = ALU_ADD;
      unique case (ID_EX_ALUOp)
         ALUOP_SUB:   alu_ctl = ALU_SUB;
         ALUOP_RTYPE: alu_ctl = funct_dec(ID_EX_SignExtImm[5:0]);
         default:     alu_ctl = ALU_ADD;
      endcase
   end

   assign alu_res = alu_calc(alu_ctl, ID_EX_ReadData1, alu_b);
   assign zero    = (ID_EX_ReadData1 - alu_b) == 32'd0;
   assign tgt     = ID_EX_PC + {ID_EX_SignExtImm[5:0], 2'b00};

`ifdef EX_MUL_EN
   logic        is_mult;
   logic        mul_busy;
   logic        mul_done;
   logic [63:0] mul_prod;
   logic        mul_hi_unused;

   assign is_mult = (ID_EX_ALUOp == ALUOP_RTYPE)
                 && (ID_EX_SignExtImm[5:0] == F_MULT);

   ex_mul_seq u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (is_mult),
      .a       (ID_EX_ReadData1),
      .b       (alu_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   assign mul_hi_unused = ^mul_prod[63:32];
   assign Stall  = mul_busy;
   assign ex_res = (is_mult && mul_done) ? mul_prod[31:0] : alu_res;
`else
   assign Stall  = 1'b0;
   assign ex_res = alu_res;
`endif

   // a stalled cycle inserts a bubble: controls drop, data holds
   always_comb begin
      res_d   = res_q;
      wdata_d = wdata_q;
      wreg_d  = wreg_q;
      m2r_d   = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      bt_d    = 1'b0;
      btgt_d  = btgt_q;
      if (!Stall) begin
         res_d   = ex_res;
         wdata_d = ID_EX_ReadData2;
         wreg_d  = ID_EX_RegDst ? ID_EX_Rd : ID_EX_Rb;
         m2r_d   = ID_EX_MemToReg;
         rw_d    = ID_EX_RegWrite;
         mr_d    = ID_EX_MemRead;
         mw_d    = ID_EX_MemWrite;
         bt_d    = ID_EX_Branch & zero;
         if (bt_d) btgt_d = tgt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_q   <= 32'd0;
         wdata_q <= 32'd0;
         wreg_q  <= 5'd0;
         m2r_q   <= 1'b0;
         rw_q    <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         bt_q    <= 1'b0;
         btgt_q  <= 8'd0;
      end else begin
         res_q   <= res_d;
         wdata_q <= wdata_d;
         wreg_q  <= wreg_d;
         m2r_q   <= m2r_d;
         rw_q    <= rw_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         bt_q    <= bt_d;
         btgt_q  <= btgt_d;
      end
   end

   assign EX_MEM_ALUResult = res_q;
   assign EX_MEM_WriteData = wdata_q;
   assign EX_MEM_WriteReg  = wreg_q;
   assign EX_MEM_MemToReg  = m2r_q;
   assign EX_MEM_RegWrite  = rw_q;
   assign EX_MEM_MemRead   = mr_q;
   assign EX_MEM_MemWrite  = mw_q;
   assign BranchTaken      = bt_q;
   assign BranchTarget     = btgt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; multiplier checks run when EX_MUL_EN
// is defined, otherwise mult is checked as a 1-cycle zero result.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b, imm;
   logic [4:0]  rd, rb;
   logic [7:0]  pc;
   logic        regdst, alusrc, m2r, rw, mr, mw, br;
   logic [1:0]  op;
   logic [31:0] res, wdata;
   logic [4:0]  wreg;
   logic        o_m2r, o_rw, o_mr, o_mw, bt, stall;
   logic [7:0]  btgt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk              (clk),
      .rst              (rst),
      .ID_EX_ReadData1  (a),
      .ID_EX_ReadData2  (b),
      .ID_EX_SignExtImm (imm),
      .ID_EX_Rd         (rd),
      .ID_EX_Rb         (rb),
      .ID_EX_PC         (pc),
      .ID_EX_RegDst     (regdst),
      .ID_EX_ALUSrc     (alusrc),
      .ID_EX_MemToReg   (m2r),
      .ID_EX_RegWrite   (rw),
      .ID_EX_MemRead    (mr),
      .ID_EX_MemWrite   (mw),
      .ID_EX_Branch     (br),
      .ID_EX_ALUOp      (op),
      .EX_MEM_ALUResult (res),
      .EX_MEM_WriteData (wdata),
      .EX_MEM_WriteReg  (wreg),
      .EX_MEM_MemToReg  (o_m2r),
      .EX_MEM_RegWrite  (o_rw),
      .EX_MEM_MemRead   (o_mr),
      .EX_MEM_MemWrite  (o_mw),
      .BranchTaken      (bt),
      .BranchTarget     (btgt),
      .Stall            (stall)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic clr();
      a = 0; b = 0; imm = 0; rd = 0; rb = 0; pc = 0; op = 2'b00;
      regdst = 0; alusrc = 0; m2r = 0; rw = 0; mr = 0; mw = 0; br = 0;
   endtask

   task automatic vec(input logic [1:0] o, input logic s,
                      input logic [31:0] va, vb, vi);
      clr();
      op = o; alusrc = s; a = va; b = vb; imm = vi;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

`ifdef EX_MUL_EN
   int n;
`endif

   initial begin
      rst = 1'b0;
      clr();
      #12;
      chk("rst_res", res, 0);
      chk("rst_wreg", {27'd0, wreg}, 0);
      chk("rst_rw", {31'd0, o_rw}, 0);
      chk("rst_bt", {31'd0, bt}, 0);
      chk("rst_btgt", {24'd0, btgt}, 0);
      chk("rst_stall", {31'd0, stall}, 0);
      @(negedge clk) rst = 1'b1;
      step();

      vec(2'b10, 0, 5, 7, 32'h22); regdst = 1; rd = 3; rw = 1;
      step();
      chk("sub_res", res, 32'hFFFFFFFE);
      chk("sub_wreg", {27'd0, wreg}, 3);
      chk("sub_rw", {31'd0, o_rw}, 1);

      vec(2'b00, 1, 100, 0, 32'hFFFFFFFC); mr = 1; m2r = 1; rw = 1;
      rb = 9; rd = 4;
      step();
      chk("lw_res", res, 96);
      chk("lw_wreg", {27'd0, wreg}, 9);
      chk("lw_mr", {31'd0, o_mr}, 1);

      vec(2'b00, 1, 32'h1000, 32'hDEADBEEF, 8); mw = 1;
      step();
      chk("sw_res", res, 32'h1008);
      chk("sw_wdata", wdata, 32'hDEADBEEF);
      chk("sw_mw", {31'd0, o_mw}, 1);
      chk("sw_rw", {31'd0, o_rw}, 0);

      vec(2'b10, 0, 32'hF0F0, 32'h0FF0, 32'h24); step();
      chk("and", res, 32'h00F0);
      vec(2'b10, 0, 32'hF0F0, 32'h0FF0, 32'h25); step();
      chk("or", res, 32'hFFF0);
      vec(2'b10, 0, 32'hFFFFFFFF, 1, 32'h2A); step();
      chk("slt_neg", res, 1);
      vec(2'b10, 0, 1, 32'hFFFFFFFF, 32'h2A); step();
      chk("slt_pos", res, 0);
      vec(2'b10, 0, 32'h1234, 32'h55, 32'h3F); step();
      chk("bad_funct", res, 0);
      vec(2'b10, 0, 32'hFFFFFFFF, 1, 32'h20); step();
      chk("add_wrap", res, 0);
      vec(2'b11, 0, 2, 3, 0); rw = 1; step();
      chk("op11_add", res, 5);

`ifdef EX_MUL_EN
      vec(2'b10, 0, 7, 32'hFFFFFFFD, 32'h18); rw = 1; regdst = 1; rd = 5;
      #1;
      n = 0;
      while (stall && n < 40) begin
         step();
         n++;
         if (n == 10) begin
            chk("bubble_rw", {31'd0, o_rw}, 0);
            chk("bubble_res", res, 5);
         end
      end
      chk("mul_stall_cycles", n, 33);
      step();
      clr();
      chk("mul_res", res, 32'hFFFFFFEB);
      chk("mul_rw", {31'd0, o_rw}, 1);
      chk("mul_wreg", {27'd0, wreg}, 5);

      vec(2'b10, 0, 9, 9, 32'h18); rw = 1;
      for (int i = 0; i < 11; i++) step();
      chk("busy_stall", {31'd0, stall}, 1);
      rst = 1'b0;
      clr();
      #1;
      chk("busy_rst_res", res, 0);
      chk("busy_rst_stall", {31'd0, stall}, 0);
      @(negedge clk) rst = 1'b1;
      vec(2'b00, 0, 10, 20, 0); rw = 1;
      #1;
      chk("post_rst_stall", {31'd0, stall}, 0);
      step();
      chk("post_rst_add", res, 30);
      chk("post_rst_rw", {31'd0, o_rw}, 1);
`else
      vec(2'b10, 0, 7, 32'hFFFFFFFD, 32'h18); rw = 1;
      #1;
      chk("mul_off_stall", {31'd0, stall}, 0);
      step();
      chk("mul_off_res", res, 0);
      chk("mul_off_rw", {31'd0, o_rw}, 1);
`endif

      vec(2'b01, 0, 3, 3, 5); br = 1; pc = 8'h10;
      step();
      chk("br_taken", {31'd0, bt}, 1);
      chk("br_tgt", {24'd0, btgt}, 32'h24);
      clr();
      step();
      chk("br_one_cycle", {31'd0, bt}, 0);
      chk("br_tgt_hold", {24'd0, btgt}, 32'h24);
      vec(2'b01, 0, 3, 4, 5); br = 1; pc = 8'h40;
      step();
      chk("br_not_taken", {31'd0, bt}, 0);
      chk("br_nt_hold", {24'd0, btgt}, 32'h24);
      vec(2'b01, 0, 0, 0, 32'h3F); br = 1; pc = 8'hF0;
      step();
      chk("br_tgt_wrap", {24'd0, btgt}, 32'hEC);

      vec(2'b00, 0, 1, 2, 0); rw = 1;
      step();
      chk("pre_rst_res", res, 3);
      rst = 1'b0;
      #1;
      chk("async_rst_res", res, 0);
      chk("async_rst_rw", {31'd0, o_rw}, 0);
      chk("async_rst_btgt", {24'd0, btgt}, 0);
      @(negedge clk) rst = 1'b1;
      vec(2'b00, 0, 10, 20, 0); rw = 1;
      step();
      chk("rel_add", res, 30);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
